// File: rtl/wb_stage_pkg.sv
// Shared core definitions for the writeback path: datapath width,
// result-source and load-type encodings, the MEM/WB entry layout and
// the result multiplexer used when an instruction is captured.
package wb_stage_pkg;

  // Datapath width of the RV32I core.
  localparam int XLEN = 32;

  // Which value an instruction writes back to rd.
  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_LOAD = 2'b01,
    RESULT_PC4  = 2'b10,
    RESULT_RSVD = 2'b11
  } result_src_e;

  // Load width/signedness taken from funct3.
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  // One retiring instruction held in the MEM/WB register.
  typedef struct packed {
    logic            valid;
    logic            done;
    logic            wr_en;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // Picks the writeback value; the reserved encoding behaves like ALU.
  function automatic logic [XLEN-1:0] select_result(
    input logic [1:0]      src,
    input logic [XLEN-1:0] alu_value,
    input logic [XLEN-1:0] load_value,
    input logic [XLEN-1:0] link_value
  );
    logic [XLEN-1:0] value;
    value = alu_value;
    case (src)
      RESULT_LOAD: value = load_value;
      RESULT_PC4:  value = link_value;
      default:     value = alu_value;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load extender: takes the raw aligned data-memory word and returns the
// byte, halfword or word addressed by the low address bits, sign- or
// zero-extended to XLEN. Purely combinational so the LSU can reuse it.
module load_ext
  import wb_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Little-endian lane pick and extension; unknown funct3 passes the word through.
  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? word[31:16] : word[15:0];
    result    = word;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LH:   result = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_lane};
      F3_LW:   result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and register-file writer. Each accepted
// instruction is captured with its final writeback value already
// selected and extended, written exactly once in the following cycle,
// exposed to the EX bypass while it is in flight, and counted in instret.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_regwrite,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_resultsrc,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_mem_rdata,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [2:0]       in_funct3,
  input  logic             hold,
  input  logic             flush,
  output logic             Regwrite,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  WD3,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret
);

  wb_entry_t       entry;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] next_data;
  logic            accept;
  logic            active;
  logic            rd_nonzero;

  assign in_ready   = !hold;
  assign accept     = in_valid && in_ready;
  assign active     = entry.valid && !entry.done;
  assign rd_nonzero = (entry.rd != 5'd0);

  load_ext u_load_ext (
    .funct3 (in_funct3),
    .offset (in_alu_result[1:0]),
    .word   (in_mem_rdata),
    .result (load_data)
  );

  assign next_data = select_result(in_resultsrc, in_alu_result, load_data, in_pc_plus4);

  // Entry register: reset beats flush beats accept beats hold; a held entry is marked done after its first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry <= '0;
    end else if (flush) begin
      entry.valid <= 1'b0;
    end else if (accept) begin
      entry.valid <= 1'b1;
      entry.done  <= 1'b0;
      entry.wr_en <= in_regwrite;
      entry.rd    <= in_rd;
      entry.data  <= next_data;
    end else if (hold) begin
      entry.done <= entry.done | entry.valid;
    end else begin
      entry.valid <= 1'b0;
    end
  end

  // Retired-instruction counter: one tick per entry on its first active cycle, even when that cycle is flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (active) begin
      count <= count + CNT_W'(1);
    end
  end

  assign Regwrite  = active && entry.wr_en && rd_nonzero;
  assign rd        = entry.rd;
  assign WD3       = entry.data;
  assign fwd_valid = entry.valid && entry.wr_en && rd_nonzero;
  assign fwd_rd    = entry.rd;
  assign fwd_data  = entry.data;
  assign instret   = count;

endmodule
